// File: rtl/conv_frame_sched_if.sv
// Pixel-in / result-out handshake bundle for conv_frame_sched.
// master = stream source and result sink, slave = the scheduler.
interface conv_frame_sched_if #(
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, out_row, out_col
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, out_row, out_col
    );
endinterface

// File: rtl/conv_frame_sched.sv
// Frame sequencer for the 3x3 convolution datapath: raster position,
// line-buffer writes, window-valid pipeline, backpressure and frame done.
module conv_frame_sched #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int LAT   = 2,
    parameter int CW    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    conv_frame_sched_if.slave   bus,
    output logic                lb_wr_en,
    output logic [1:0]          lb_sel,
    output logic [CW-1:0]       lb_wr_addr,
    output logic                win_valid,
    output logic                pipe_en,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   row_q, row_d;
    logic [1:0]      sel_q, sel_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [CW-1:0]   trow_q [LAT];
    logic [CW-1:0]   trow_d [LAT];
    logic [CW-1:0]   tcol_q [LAT];
    logic [CW-1:0]   tcol_d [LAT];
    logic            stall;
    logic            last_px;

    // Output decode: handshakes, stall and line-buffer strobes.
    always_comb begin
        bus.out_valid = vld_q[LAT-1];
        bus.out_row   = trow_q[LAT-1];
        bus.out_col   = tcol_q[LAT-1];
        stall         = vld_q[LAT-1] && !bus.out_ready;
        pipe_en       = !stall;
        bus.in_ready  = (state_q == S_RUN) && !stall;
        lb_wr_en      = bus.in_valid && bus.in_ready;
        lb_wr_addr    = col_q;
        lb_sel        = sel_q;
        win_valid     = lb_wr_en && (row_q >= CW'(2)) && (col_q >= CW'(2));
        busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
        done          = (state_q == S_DONE);
    end

    // Raster position and line-buffer rotation, advanced per accepted pixel.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        sel_d   = sel_q;
        last_px = (col_q == CW'(IMG_W - 1)) && (row_q == CW'(IMG_H - 1));
        if (lb_wr_en) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == CW'(IMG_H - 1)) begin
                    row_d = '0;
                    sel_d = 2'd0;
                end else begin
                    row_d = row_q + CW'(1);
                    sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Valid/tag pipeline alongside the adder tree; frozen while stalled.
    always_comb begin
        vld_d  = vld_q;
        trow_d = trow_q;
        tcol_d = tcol_q;
        if (pipe_en) begin
            vld_d[0]  = win_valid;
            trow_d[0] = row_q - CW'(2);
            tcol_d[0] = col_q - CW'(2);
            for (int i = 1; i < LAT; i++) begin
                vld_d[i]  = vld_q[i-1];
                trow_d[i] = trow_q[i-1];
                tcol_d[i] = tcol_q[i-1];
            end
        end
    end

    // Frame FSM next state; drain ends once the last result has left.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (lb_wr_en && last_px) state_d = S_DRAIN;
            S_DRAIN: if (vld_d == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= 2'd0;
            vld_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                trow_q[i] <= '0;
                tcol_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            trow_q  <= trow_d;
            tcol_q  <= tcol_d;
        end
    end
endmodule

// File: tb/tb_conv_frame_sched.sv
// Bench for conv_frame_sched: scenario table plus hand-written corner
// sequences, with a tag scoreboard on the result stream.
module tb_conv_frame_sched;
    localparam int W   = 28;
    localparam int H   = 28;
    localparam int LAT = 2;
    localparam int CW  = 5;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          lb_wr_en;
    logic [1:0]    lb_sel;
    logic [CW-1:0] lb_wr_addr;
    logic          win_valid;
    logic          pipe_en;
    logic          busy;
    logic          done;

    conv_frame_sched_if #(.CW(CW)) bus ();

    conv_frame_sched #(
        .IMG_W(W), .IMG_H(H), .LAT(LAT), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .lb_wr_en   (lb_wr_en),
        .lb_sel     (lb_sel),
        .lb_wr_addr (lb_wr_addr),
        .win_valid  (win_valid),
        .pipe_en    (pipe_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int cyc;
    } tag_t;

    typedef struct {
        int piv;
        int por;
        bit mst;
        bit frz;
        int exp_out;
    } vec_t;

    tag_t sb[$];
    vec_t tbl[5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int piv, por;
    int mr, mc, msel;
    int acc_n, nout, ndone;
    int done_cyc, last_out_cyc;
    int frz_left, hold_left;
    bit frz_arm, hold_mode, lat_chk, first_win;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit st);
        bit   iv, ordy;
        tag_t e;
        @(negedge clk);
        iv   = ($urandom_range(99) < piv);
        ordy = ($urandom_range(99) < por);
        if (frz_arm && bus.out_valid) begin
            frz_left = 5;
            frz_arm  = 1'b0;
        end
        if (frz_left > 0) ordy = 1'b0;
        if (hold_mode && acc_n == W * H && bus.out_valid &&
            sb.size() == 1 && hold_left > 0) begin
            ordy = 1'b0;
            hold_left--;
            chk("hold_no_done", done, 0);
            chk("hold_busy", busy, 1);
        end
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        start         = st;
        #1;
        cyc++;
        if (frz_left > 0) begin
            frz_left--;
            chk("frz_in_ready", bus.in_ready, 0);
            chk("frz_pipe_en", pipe_en, 0);
            if (sb.size() > 0) begin
                chk("frz_row", bus.out_row, sb[0].r);
                chk("frz_col", bus.out_col, sb[0].c);
            end
        end
        chk("pipe_en", pipe_en, !(bus.out_valid && !bus.out_ready));
        if (bus.in_valid && bus.in_ready) begin
            acc_n++;
            chk("lb_wr_en", lb_wr_en, 1);
            chk("lb_wr_addr", lb_wr_addr, mc);
            chk("lb_sel", lb_sel, msel);
            chk("win_valid", win_valid, (mr >= 2 && mc >= 2));
            if (mr >= 2 && mc >= 2) begin
                sb.push_back('{r: mr - 2, c: mc - 2, cyc: cyc});
                if (!first_win) begin
                    first_win = 1'b1;
                    chk("first_win_acc", acc_n, 2 * W + 3);
                end
            end
            if (mc == W - 1) begin
                mc = 0;
                if (mr == H - 1) begin
                    mr   = 0;
                    msel = 0;
                end else begin
                    mr++;
                    msel = (msel + 1) % 3;
                end
            end else begin
                mc++;
            end
        end else begin
            chk("no_wr", lb_wr_en, 0);
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_row", bus.out_row, e.r);
                chk("out_col", bus.out_col, e.c);
                if (lat_chk) chk("latency", cyc - e.cyc, LAT);
            end
            nout++;
            last_out_cyc = cyc;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    task automatic init_frame(input int piv_i, input int por_i,
                              input bit frz, input bit hold);
        piv       = piv_i;
        por       = por_i;
        frz_arm   = frz;
        frz_left  = 0;
        hold_mode = hold;
        hold_left = 4;
        lat_chk   = (por_i == 100) && !frz && !hold;
        mr = 0; mc = 0; msel = 0;
        acc_n = 0; nout = 0; ndone = 0;
        done_cyc = 0; last_out_cyc = 0;
        first_win = 1'b0;
        sb.delete();
    endtask

    task automatic run_frame(input int piv_i, input int por_i,
                             input bit mst, input bit frz,
                             input bit hold, input int exp_out);
        bit ms_done;
        int guard;
        int post;
        ms_done = 1'b0;
        guard   = 0;
        post    = 0;
        init_frame(piv_i, por_i, frz, hold);
        step(1'b1);
        while (guard < 6000 && post < 2) begin
            bit s;
            s = 1'b0;
            if (mst && !ms_done && acc_n == 100) begin
                s       = 1'b1;
                ms_done = 1'b1;
            end
            step(s);
            if (s) chk("busy_mid_start", busy, 1);
            if (ndone > 0) post++;
            guard++;
        end
        chk("frame_done_cnt", ndone, 1);
        chk("frame_outputs", nout, exp_out);
        chk("sb_drained", sb.size(), 0);
        chk("done_after_last", done_cyc - last_out_cyc, 1);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", bus.in_ready, 0);
        if (hold) chk("hold_used", hold_left, 0);
    endtask

    initial begin
        int guard;
        tbl[0] = '{piv: 100, por: 100, mst: 0, frz: 0, exp_out: NOUT};
        tbl[1] = '{piv: 50,  por: 100, mst: 0, frz: 0, exp_out: NOUT};
        tbl[2] = '{piv: 100, por: 100, mst: 0, frz: 1, exp_out: NOUT};
        tbl[3] = '{piv: 70,  por: 100, mst: 1, frz: 0, exp_out: NOUT};
        tbl[4] = '{piv: 60,  por: 70,  mst: 0, frz: 0, exp_out: NOUT};

        reset         = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lb_sel", lb_sel, 0);
        chk("rst_out_row", bus.out_row, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].piv, tbl[i].por, tbl[i].mst,
                      tbl[i].frz, 1'b0, tbl[i].exp_out);
        end

        run_frame(100, 100, 1'b0, 1'b0, 1'b1, NOUT);

        init_frame(100, 100, 1'b0, 1'b0);
        step(1'b1);
        guard = 0;
        while (acc_n < 300 && guard < 2000) begin
            step(1'b0);
            guard++;
        end
        chk("abort_accepts", acc_n, 300);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_out_row", bus.out_row, 0);
        chk("abort_out_col", bus.out_col, 0);
        chk("abort_lb_sel", lb_sel, 0);
        chk("abort_wr_addr", lb_wr_addr, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_frame(100, 100, 1'b0, 1'b0, 1'b0, NOUT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
